// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary to BCD converter.
// One input bit per clock, MSB first, optional leading-zero blanking.
module bin_to_bcd #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int LZ_BLANK = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [WIDTH-1:0]    BinIn,
    output logic [4*DIGITS-1:0] BcdOut,
    output logic                Busy,
    output logic                Done
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [WIDTH-1:0] sreg;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  adj;
    logic [CW-1:0]  cnt;
    logic           last;

    // Replace every digit above the top nonzero digit with 4'hF.
    // Digit 0 is never blanked so zero still shows "0".
    function automatic logic [AW-1:0] blank(input logic [AW-1:0] a);
        logic          seen;
        logic [AW-1:0] r;
        seen = 1'b0;
        r    = a;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (a[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if ((LZ_BLANK != 0) && !seen) begin
                r[4*i +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    assign last = (cnt == CW'(WIDTH));

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (Start) state_n = SHIFT;
            SHIFT:   if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register with registered Busy/Done flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_n;
            Busy  <= (state_n != IDLE);
            Done  <= (state_n == DONE);
        end
    end

    // Shift register, accumulator, counter and result register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sreg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            BcdOut <= blank('0);
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        sreg <= BinIn;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (!last) begin
                        {acc, sreg} <= {adj, sreg} << 1;
                        cnt         <= cnt + CW'(1);
                    end else begin
                        BcdOut <= blank(acc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed cases plus random
// values compared with a decimal reference model.
module tb_bin_to_bcd;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] BinIn;
    logic [19:0] BcdOut;
    logic        Busy;
    logic        Done;
    logic [19:0] BcdOut2;
    logic        Busy2;
    logic        Done2;

    int errors = 0;
    int checks = 0;

    bin_to_bcd #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BinIn(BinIn),
        .BcdOut(BcdOut), .Busy(Busy), .Done(Done)
    );

    bin_to_bcd #(.WIDTH(16), .DIGITS(5), .LZ_BLANK(0)) dut2 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BinIn(BinIn),
        .BcdOut(BcdOut2), .Busy(Busy2), .Done(Done2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Decimal reference: digit i blanked when value < 10**i.
    function automatic logic [19:0] ref_bcd(input int v, input bit lz);
        logic [19:0] r;
        int          p;
        int          d;
        p = 1;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            d = (v / p) % 10;
            if (lz && i > 0 && v < p) d = 15;
            r[4*i +: 4] = 4'(d);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind 1: re-Start with alt at shift act; kind 2: Reset at shift act.
    task automatic run_conv(input int v, input int act, input int kind,
                            input int alt, output int done_at,
                            output int pulses, output int busy_n,
                            output logic busy_after);
        BinIn = 16'(v);
        Start = 1'b1;
        tick();
        Start      = 1'b0;
        busy_n     = Busy ? 1 : 0;
        done_at    = -1;
        pulses     = 0;
        busy_after = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            if (i == act) begin
                if (kind == 1) begin
                    BinIn = 16'(alt);
                    Start = 1'b1;
                end else begin
                    Reset = 1'b1;
                end
            end
            tick();
            if (i == act) begin
                Start = 1'b0;
                Reset = 1'b0;
                if (kind == 2) busy_after = Busy;
            end
            if (Busy) busy_n++;
            if (Done) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
    endtask

    initial begin
        int          d_at;
        int          np;
        int          nb;
        logic        ba;
        int          v;
        int          dn[$];
        bit          seen;
        int          t;

        Reset = 1'b1;
        Start = 1'b0;
        BinIn = '0;
        tick();
        tick();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_bcd", 32'(BcdOut), 32'h000FFFF0);
        chk("rst_bcd_nolz", 32'(BcdOut2), 32'h0);

        Start = 1'b1;
        BinIn = 16'd555;
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        chk("start_with_reset", 32'(Busy), 32'd0);

        run_conv(1234, 0, 0, 0, d_at, np, nb, ba);
        chk("1234_latency", 32'(d_at), 32'd17);
        chk("1234_pulses", 32'(np), 32'd1);
        chk("1234_busy", 32'(nb), 32'd18);
        chk("1234_bcd", 32'(BcdOut), 32'h000F1234);
        chk("1234_nolz", 32'(BcdOut2), 32'h00001234);

        run_conv(65535, 0, 0, 0, d_at, np, nb, ba);
        chk("65535_bcd", 32'(BcdOut), 32'h00065535);
        run_conv(0, 0, 0, 0, d_at, np, nb, ba);
        chk("0_bcd", 32'(BcdOut), 32'h000FFFF0);
        chk("0_nolz", 32'(BcdOut2), 32'h0);
        run_conv(10000, 0, 0, 0, d_at, np, nb, ba);
        chk("10000_bcd", 32'(BcdOut), 32'h00010000);
        run_conv(7, 0, 0, 0, d_at, np, nb, ba);
        chk("7_bcd", 32'(BcdOut), 32'h000FFFF7);
        chk("7_nolz", 32'(BcdOut2), 32'h00000007);

        run_conv(1111, 5, 1, 2222, d_at, np, nb, ba);
        chk("restart_pulses", 32'(np), 32'd1);
        chk("restart_latency", 32'(d_at), 32'd17);
        chk("restart_bcd", 32'(BcdOut), 32'h000F1111);

        run_conv(4321, 8, 2, 0, d_at, np, nb, ba);
        chk("abort_busy", 32'(ba), 32'd0);
        chk("abort_pulses", 32'(np), 32'd0);
        chk("abort_bcd", 32'(BcdOut), 32'h000FFFF0);

        BinIn = 16'd99;
        Start = 1'b1;
        tick();
        BinIn = 16'd100;
        seen  = 1'b0;
        for (int i = 1; i <= 60 && dn.size() < 2; i++) begin
            tick();
            if (Done) begin
                dn.push_back(i);
                if (!seen) begin
                    chk("b2b_first", 32'(BcdOut), 32'h000FFF99);
                    seen = 1'b1;
                end else begin
                    chk("b2b_second", 32'(BcdOut), 32'h000FF100);
                end
            end
        end
        Start = 1'b0;
        chk("b2b_count", 32'(dn.size()), 32'd2);
        if (dn.size() == 2) begin
            chk("b2b_first_at", 32'(dn[0]), 32'd17);
            chk("b2b_period", 32'(dn[1] - dn[0]), 32'd19);
        end
        tick();
        tick();

        for (int n = 0; n < 2000; n++) begin
            if (n % 4 == 0) v = int'($urandom_range(0, 99));
            else v = int'($urandom_range(0, 65535));
            BinIn = 16'(v);
            Start = 1'b1;
            tick();
            Start = 1'b0;
            BinIn = 16'($urandom);
            t = 0;
            while (!Done && t < 30) begin
                tick();
                t++;
            end
            if (!Done) begin
                chk("rand_timeout", 32'(t), 32'd17);
            end else begin
                chk("rand_lz", 32'(BcdOut), 32'(ref_bcd(v, 1'b1)));
                chk("rand_nolz", 32'(BcdOut2), 32'(ref_bcd(v, 1'b0)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
